// File: rtl/pl_mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and
// default widths used by the top level and its winner-select helper.
package pl_mem_arbiter_pkg;

  localparam int AW_DEFAULT           = 32;
  localparam int DW_DEFAULT           = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } state_t;

endpackage

// File: rtl/pl_mem_arb_pick.sv
// Winner select between fetch and data requesters, plus the saturating
// counter that forces a fetch grant after a run of data grants.
module pl_mem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              clrn,
  input  logic                              idle,
  input  logic                              i_req,
  input  logic                              d_req,
  output logic                              grant_i,
  output logic                              grant_d,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Data normally wins so the older MEM-stage instruction drains first.
  assign grant_d = idle && d_req && (!i_req || (starve_cnt < LIMIT));
  assign grant_i = idle && i_req && !grant_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pl_mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the
// pipeline: arbitrates, latches the winner, runs the req/ack handshake.
module pl_mem_arbiter
  import pl_mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              clrn,
  input  logic                              i_req,
  input  logic [AW-1:0]                     i_addr,
  output logic                              i_rdy,
  output logic [DW-1:0]                     i_rdata,
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [AW-1:0]                     d_addr,
  input  logic [DW-1:0]                     d_wdata,
  output logic                              d_rdy,
  output logic [DW-1:0]                     d_rdata,
  output logic                              m_req,
  output logic                              m_we,
  output logic [AW-1:0]                     m_addr,
  output logic [DW-1:0]                     m_wdata,
  input  logic                              m_ack,
  input  logic [DW-1:0]                     m_rdata,
  output logic                              busy,
  output state_t                            state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt
);

  // Handshake: a requester raises x_req and holds it (with stable operands)
  // until x_rdy pulses; m_req is held until a single-cycle m_ack returns data.
  logic          grant_i;
  logic          grant_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;

  pl_mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk        (clk),
    .clrn       (clrn),
    .idle       (state == ST_IDLE),
    .i_req      (i_req),
    .d_req      (d_req),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .starve_cnt (starve_cnt)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      m_req   <= 1'b0;
      i_rdy   <= 1'b0;
      d_rdy   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state   <= ST_BUSY_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
            m_req   <= 1'b1;
            busy    <= 1'b1;
          end else if (grant_i) begin
            state  <= ST_BUSY_I;
            addr_q <= i_addr;
            we_q   <= 1'b0;
            m_req  <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // Stores capture m_rdata too; the value is simply never consumed.
          if (m_ack) begin
            rdata_q <= m_rdata;
            m_req   <= 1'b0;
            if (state == ST_BUSY_I) begin
              state <= ST_RESP_I;
              i_rdy <= 1'b1;
            end else begin
              state <= ST_RESP_D;
              d_rdy <= 1'b1;
            end
          end
        end
        ST_RESP_I, ST_RESP_D: begin
          state <= ST_IDLE;
          i_rdy <= 1'b0;
          d_rdy <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          m_req <= 1'b0;
          i_rdy <= 1'b0;
          d_rdy <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_addr  = addr_q;
  assign m_we    = we_q;
  assign m_wdata = wdata_q;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Directed and randomised-wait bench for pl_mem_arbiter with a behavioural
// variable-latency memory and per-port expected-data queues.
module tb_pl_mem_arbiter;
  import pl_mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int CW = $clog2(SL + 1);

  logic          clk = 1'b0;
  logic          clrn;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_rdy, d_rdy, m_req, m_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic          mdl_ack, spur_ack;
  logic          m_ack;
  state_t        state;
  logic [CW-1:0] starve_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] i_exp_q [$];
  logic [DW-1:0] d_exp_q [$];
  int   mem_wait = 0;
  bit   mem_rand = 1'b0;
  bit   mon_en   = 1'b0;

  assign m_ack = mdl_ack | spur_ack;

  pl_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .clrn(clrn),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .busy(busy), .state(state), .starve_cnt(starve_cnt)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // ---------------- behavioural memory ----------------
  initial begin
    int cnt;
    int cur_wait;
    bit active;
    cnt = 0; cur_wait = 0; active = 1'b0;
    mdl_ack = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        mdl_ack = 1'b0; active = 1'b0; cnt = 0;
      end else if (mdl_ack) begin
        mdl_ack = 1'b0;
      end else if (m_req) begin
        if (!active) begin
          active = 1'b1; cnt = 0;
          cur_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
        end
        if (cnt >= cur_wait) begin
          mdl_ack = 1'b1; active = 1'b0;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            m_rdata = ~m_wdata;
          end else begin
            m_rdata = mem.exists(m_addr) ? mem[m_addr] : pat(m_addr);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && (i_rdy || d_rdy)) begin
      checks++;
      if (i_rdy && d_rdy) begin
        errors++;
        $display("FAIL rdy_overlap got i_rdy=%b d_rdy=%b want at most one", i_rdy, d_rdy);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_req, m_we, i_rdy, d_rdy, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {m_req, m_we, i_rdy, d_rdy, busy});
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0", m_addr, m_wdata, i_rdata, d_rdata);
    end
    checks++;
    if (state !== ST_IDLE || starve_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d want 0/0", state, starve_cnt);
    end
    clrn = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %0d/%b want 0/0", state, busy);
    end
  endtask

  task automatic test_lone_fetch();
    int rdy_at, pulses;
    rdy_at = -1; pulses = 0;
    mem_wait = 2;
    mem[32'h40] = 32'h8C22_0004;
    i_addr = 32'h40; i_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0) begin
          errors++;
          $display("FAIL fetch_mreq k=%0d got req=%b addr=%h we=%b want 1/00000040/0", k, m_req, m_addr, m_we);
        end
      end
      if (i_rdy === 1'b1) begin
        pulses++;
        if (rdy_at < 0) rdy_at = k;
        checks++;
        if (i_rdata !== 32'h8C22_0004) begin
          errors++;
          $display("FAIL fetch_rdata got %h want 8c220004", i_rdata);
        end
        i_req = 1'b0;
      end
    end
    checks++;
    if (rdy_at != 4 || pulses != 1) begin
      errors++;
      $display("FAIL fetch_latency got cycle %0d pulses %0d want cycle 4 pulses 1", rdy_at, pulses);
    end
  endtask

  task automatic test_store();
    int req_cycles, rdy_at, i_seen;
    req_cycles = 0; rdy_at = -1; i_seen = 0;
    mem_wait = 0;
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL store_mem got req=%b we=%b addr=%h wdata=%h want 1/1/00000100/deadbeef",
                   m_req, m_we, m_addr, m_wdata);
        end
      end
      if (m_req === 1'b1) req_cycles++;
      if (i_rdy === 1'b1) i_seen++;
      if (d_rdy === 1'b1 && rdy_at < 0) begin
        rdy_at = k; d_req = 1'b0; d_we = 1'b0;
      end
    end
    checks++;
    if (rdy_at != 2 || req_cycles != 1 || i_seen != 0) begin
      errors++;
      $display("FAIL store_timing got rdy=%0d mreq_cycles=%0d i_rdy=%0d want 2/1/0", rdy_at, req_cycles, i_seen);
    end
    checks++;
    if (!mem.exists(32'h100) || mem[32'h100] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_written want deadbeef at 00000100");
    end
  endtask

  task automatic test_contention();
    int d_at, i_at;
    logic [DW-1:0] d_val, i_val;
    d_at = -1; i_at = -1; d_val = '0; i_val = '0;
    mem_wait = 1;
    d_we = 1'b0; d_addr = 32'h100; i_addr = 32'h44;
    d_req = 1'b1; i_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (d_rdy === 1'b1 && d_at < 0) begin d_at = k; d_val = d_rdata; d_req = 1'b0; end
      if (i_rdy === 1'b1 && i_at < 0) begin i_at = k; i_val = i_rdata; i_req = 1'b0; end
    end
    checks++;
    if (d_at != 3 || d_val !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL contention_data got cycle %0d data %h want cycle 3 data deadbeef", d_at, d_val);
    end
    checks++;
    if (i_at != 7 || i_val !== pat(32'h44)) begin
      errors++;
      $display("FAIL contention_fetch got cycle %0d data %h want cycle 7 data %h", i_at, i_val, pat(32'h44));
    end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    spur_ack = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    spur_ack = 1'b0;
    checks++;
    if (state !== ST_IDLE || busy !== 1'b0 || m_req !== 1'b0 || i_rdy !== 1'b0 || d_rdy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack got state=%0d busy=%b mreq=%b rdy=%b%b want idle, all 0",
               state, busy, m_req, i_rdy, d_rdy);
    end
    checks++;
    if (i_rdata !== pat(32'h44)) begin
      errors++;
      $display("FAIL spurious_rdata got %h want %h", i_rdata, pat(32'h44));
    end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_g, got_g;
    int ng, nd;
    state_t prev;
    exp_g = 10'b10_0001_0000;
    got_g = '0; ng = 0; nd = 0;
    mem_wait = 0;
    d_we = 1'b0; d_addr = 32'h104; i_addr = 32'h48;
    prev = state;
    d_req = 1'b1; i_req = 1'b1;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      if (d_rdy === 1'b1) nd++;
      if (prev == ST_IDLE && state == ST_BUSY_I) begin got_g[ng] = 1'b1; ng++; end
      else if (prev == ST_IDLE && state == ST_BUSY_D) begin got_g[ng] = 1'b0; ng++; end
      prev = state;
    end
    d_req = 1'b0;
    for (int c = 0; c < 20 && i_rdy !== 1'b1; c++) @(negedge clk);
    i_req = 1'b0;
    checks++;
    if (ng != 10 || got_g !== exp_g) begin
      errors++;
      $display("FAIL starve_order got %0d grants %b want 10 grants %b (bit=1 fetch)", ng, got_g, exp_g);
    end
    checks++;
    if (nd != 8) begin
      errors++;
      $display("FAIL starve_data_done got %0d want 8", nd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    mem_wait = 8;
    d_we = 1'b0; d_addr = 32'h108; i_addr = 32'h4C;
    d_req = 1'b1; i_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== ST_BUSY_D || m_req !== 1'b1 || starve_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL midreset_pre got state=%0d mreq=%b cnt=%0d want 2/1/1", state, m_req, starve_cnt);
    end
    #2 clrn = 1'b0;
    #1;
    checks++;
    if (m_req !== 1'b0 || busy !== 1'b0 || i_rdy !== 1'b0 || d_rdy !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_async got mreq=%b busy=%b rdy=%b%b state=%0d want all 0",
               m_req, busy, i_rdy, d_rdy, state);
    end
    d_req = 1'b0; i_req = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || starve_cnt !== '0 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_post got state=%0d cnt=%0d mreq=%b want 0/0/0", state, starve_cnt, m_req);
    end
  endtask

  // ---------------- stress drivers ----------------
  task automatic drive_fetch(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    int t;
    for (int k = 0; k < n; k++) begin
      a = 32'h2000 + AW'($urandom_range(0, 255)) * 4;
      i_addr = a; i_req = 1'b1;
      i_exp_q.push_back(pat(a));
      t = 0;
      do begin @(negedge clk); t++; end while (i_rdy !== 1'b1 && t < 100);
      if (i_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stress_fetch_timeout op %0d got no i_rdy want i_rdy within 100 cycles", k);
        i_req = 1'b0;
        return;
      end
      exp = i_exp_q.pop_front();
      checks++;
      if (i_rdata !== exp) begin
        errors++;
        $display("FAIL stress_fetch op %0d addr %h got %h want %h", k, a, i_rdata, exp);
      end
      if ($urandom_range(0, 1) == 1) begin
        i_req = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    i_req = 1'b0;
  endtask

  task automatic drive_data(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] wd, exp;
    logic we;
    int t;
    for (int k = 0; k < n; k++) begin
      a  = 32'h1000 + AW'($urandom_range(0, 15)) * 4;
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom();
      d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1;
      if (we) ref_mem[a] = wd;
      else d_exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : pat(a));
      t = 0;
      do begin @(negedge clk); t++; end while (d_rdy !== 1'b1 && t < 100);
      if (d_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stress_data_timeout op %0d got no d_rdy want d_rdy within 100 cycles", k);
        d_req = 1'b0;
        return;
      end
      if (!we) begin
        exp = d_exp_q.pop_front();
        checks++;
        if (d_rdata !== exp) begin
          errors++;
          $display("FAIL stress_load op %0d addr %h got %h want %h", k, a, d_rdata, exp);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        d_req = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    d_req = 1'b0;
  endtask

  task automatic test_stress();
    mem_rand = 1'b1;
    mon_en   = 1'b1;
    fork
      drive_fetch(500);
      drive_data(500);
    join
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (i_exp_q.size() != 0 || d_exp_q.size() != 0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL stress_drain got queues %0d/%0d state %0d want 0/0/0",
               i_exp_q.size(), d_exp_q.size(), state);
    end
  endtask

  initial begin
    clrn = 1'b0; spur_ack = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_lone_fetch();
    test_store();
    test_contention();
    test_spurious_ack();
    test_starvation();
    test_reset_mid_busy();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
